mtm_alu_sout_tx: RTL and testbench

//  Serial result transmitter of the mtm_alu: takes one result (C + flags + CRC) or one error report per

---
 rtl/mtm_alu_pkg.sv | 67 ++++++
 rtl/mtm_alu_frame_shifter.sv | 60 ++++++
 rtl/mtm_alu_sout_tx.sv | 123 ++++++++++++
 tb/tb_mtm_alu_sout_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared types, frame constants and CRC3 helper for the mtm_alu result transmitter.
// Used by mtm_alu_sout_tx; MTM_ALU_TX_CRC_GEN_EN selects internal CRC generation there.
package mtm_alu_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned RES_FRAMES = 5;
  localparam int unsigned ERR_FRAMES = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  typedef enum logic {
    FT_DATA = 1'b0,
    FT_CTL  = 1'b1
  } frame_type_t;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flag_s;

  typedef struct packed {
    logic err_data;
    logic err_crc;
    logic err_op;
  } err_flag_s;

  // CRC3, poly x^3+x+1, init 0, data consumed MSB first
  function automatic logic [2:0] crc3_37(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = c[2] ^ d[36-i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  // Returns {type, payload} for frame idx of a packet
  function automatic logic [8:0] tx_frame(input logic is_err, input logic [31:0] c,
                                          input flag_s fl, input logic [2:0] crc,
                                          input err_flag_s ef, input logic [2:0] idx);
    logic [6:0] e;
    logic [8:0] f;
    e = {1'b1, ef, ef};
    f = '0;
    if (is_err) begin
      f = {FT_CTL, e, ^e};
    end else begin
      case (idx)
        3'd0:    f = {FT_DATA, c[31:24]};
        3'd1:    f = {FT_DATA, c[23:16]};
        3'd2:    f = {FT_DATA, c[15:8]};
        3'd3:    f = {FT_DATA, c[7:0]};
        default: f = {FT_CTL, 1'b0, fl, crc};
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/mtm_alu_frame_shifter.sv
// Serialises one 11-bit frame: start 0, {type,payload} MSB first, stop 1; line rests at 1.
// o_done is high during the final cycle of the stop bit so the next frame can load seamlessly.
module mtm_alu_frame_shifter
  import mtm_alu_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [8:0] i_frame,
  output logic       o_sout,
  output logic       o_done
);

  localparam int unsigned    BW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(FRAME_BITS - 1);

  logic          r_active;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [BW-1:0] r_baud_cnt;
  logic          r_sout;

  assign o_sout = r_sout;
  assign o_done = r_active && (r_baud_cnt == BAUD_LAST) && (r_bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active   <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_sout     <= 1'b1;
    end else if (i_load) begin
      r_active   <= 1'b1;
      r_shift    <= {i_frame, 1'b1};
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_sout     <= 1'b0;
    end else if (r_active) begin
      if (r_baud_cnt == BAUD_LAST) begin
        r_baud_cnt <= '0;
        if (r_bit_cnt == BIT_LAST) begin
          r_active  <= 1'b0;
          r_bit_cnt <= '0;
          r_sout    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_sout    <= r_shift[9];
          r_shift   <= {r_shift[8:0], 1'b0};
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mtm_alu_sout_tx.sv
// mtm_alu result/error serial transmitter: one packet per valid/ready handshake.
// Define MTM_ALU_TX_CRC_GEN_EN to compute the CTL CRC3 internally instead of sending res_crc.
module mtm_alu_sout_tx
  import mtm_alu_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned IDLE_GAP   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic        res_is_err,
  input  logic [31:0] res_c,
  input  logic [3:0]  res_flags,
  input  logic [2:0]  res_crc,
  input  logic [2:0]  res_err_flags,
  output logic        sout,
  output logic        busy
);

  localparam int unsigned   BW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned   GW        = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  tx_state_t     r_state;
  logic          r_is_err;
  logic [31:0]   r_c;
  flag_s         r_flags;
  err_flag_s     r_err;
  logic [2:0]    r_frame_cnt;
  logic [BW-1:0] r_gap_baud;
  logic [GW-1:0] r_gap_cnt;

  logic       w_done;
  logic       w_more;
  logic       w_gap_end;
  logic       w_frame_end;
  logic       w_hs;
  logic       w_load;
  logic [2:0] w_crc;
  logic [8:0] w_frame;

`ifdef MTM_ALU_TX_CRC_GEN_EN
  logic w_unused_crc;
  assign w_unused_crc = ^res_crc;
  assign w_crc        = crc3_37({r_c, 1'b0, r_flags});
`else
  logic [2:0] r_crc;
  assign w_crc = r_crc;
`endif

  assign w_more      = !r_is_err && (r_frame_cnt < 3'(RES_FRAMES - 1));
  assign w_gap_end   = (r_state == TX_GAP) && (r_gap_baud == BAUD_LAST) && (r_gap_cnt == GAP_LAST);
  assign w_frame_end = (IDLE_GAP == 0) ? ((r_state == TX_SHIFT) && w_done) : w_gap_end;

  // Ready also during the last cycle of a packet, so a waiting word follows with no idle bit.
  assign res_ready = (r_state == TX_IDLE) || (w_frame_end && !w_more);
  assign busy      = !res_ready;
  assign w_hs      = res_valid && res_ready;
  assign w_load    = w_hs || (w_frame_end && w_more);

  assign w_frame = w_hs
    ? tx_frame(res_is_err, res_c, flag_s'(res_flags), w_crc, err_flag_s'(res_err_flags), 3'd0)
    : tx_frame(r_is_err, r_c, r_flags, w_crc, r_err, r_frame_cnt + 3'd1);

  mtm_alu_frame_shifter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_frame(w_frame),
    .o_sout (sout),
    .o_done (w_done)
  );

  // Frame loading happens on the transition edge itself, keeping start bits one cycle after a handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= TX_IDLE;
      r_is_err    <= 1'b0;
      r_c         <= '0;
      r_flags     <= '0;
      r_err       <= '0;
      r_frame_cnt <= '0;
      r_gap_baud  <= '0;
      r_gap_cnt   <= '0;
`ifndef MTM_ALU_TX_CRC_GEN_EN
      r_crc       <= '0;
`endif
    end else begin
      if (r_state == TX_GAP) begin
        if (r_gap_baud == BAUD_LAST) begin
          r_gap_baud <= '0;
          r_gap_cnt  <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + 1'b1;
        end else begin
          r_gap_baud <= r_gap_baud + 1'b1;
        end
      end
      if ((r_state == TX_SHIFT) && w_done && (IDLE_GAP != 0)) begin
        r_state <= TX_GAP;
      end
      if (w_frame_end) begin
        r_state     <= w_more ? TX_SHIFT : TX_IDLE;
        r_frame_cnt <= w_more ? r_frame_cnt + 3'd1 : '0;
      end
      if (w_hs) begin
        r_state     <= TX_SHIFT;
        r_frame_cnt <= '0;
        r_is_err    <= res_is_err;
        r_c         <= res_c;
        r_flags     <= flag_s'(res_flags);
        r_err       <= err_flag_s'(res_err_flags);
`ifndef MTM_ALU_TX_CRC_GEN_EN
        r_crc       <= res_crc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_sout_tx.sv
// Directed bench for mtm_alu_sout_tx: serial frame monitors on two instances (1 and 3 cycles/bit).
// Honours MTM_ALU_TX_CRC_GEN_EN when computing the expected CTL crc field.
module tb_mtm_alu_sout_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        is_err = 1'b0;
  logic [31:0] c = '0;
  logic [3:0]  fl = '0;
  logic [2:0]  crc = '0, ef = '0;
  logic        rdy1, busy1, so1, rdy3, busy3, so3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mtm_alu_sout_tx #(.BIT_CYCLES(1), .IDLE_GAP(2)) dut (
    .clk(clk), .reset(reset), .res_valid(v1), .res_ready(rdy1), .res_is_err(is_err),
    .res_c(c), .res_flags(fl), .res_crc(crc), .res_err_flags(ef), .sout(so1), .busy(busy1));

  mtm_alu_sout_tx #(.BIT_CYCLES(3), .IDLE_GAP(0)) dut3 (
    .clk(clk), .reset(reset), .res_valid(v3), .res_ready(rdy3), .res_is_err(is_err),
    .res_c(c), .res_flags(fl), .res_crc(crc), .res_err_flags(ef), .sout(so3), .busy(busy3));

  typedef struct {
    logic [8:0] fr;
    logic       stop;
    logic       ok;
    int         t;
  } mon_t;

  mon_t q1[$];
  mon_t q3[$];

  logic       m1_in = 1'b0;
  int         m1_k = 0, m1_t = 0;
  logic [9:0] m1_sh = '0;

  always @(negedge clk) begin
    if (reset) begin
      m1_in = 1'b0;
    end else if (!m1_in) begin
      if (so1 === 1'b0) begin
        m1_in = 1'b1; m1_k = 0; m1_t = cyc;
      end
    end else begin
      m1_sh = {m1_sh[8:0], so1};
      m1_k++;
      if (m1_k == 10) begin
        q1.push_back('{fr: m1_sh[9:1], stop: m1_sh[0], ok: 1'b1, t: m1_t});
        m1_in = 1'b0;
      end
    end
  end

  logic        m3_in = 1'b0, m3_ok;
  int          m3_k = 0, m3_t = 0;
  logic [32:0] m3_sh = '0;
  logic [2:0]  m3_g;
  logic [10:0] m3_b;

  always @(negedge clk) begin
    if (reset) begin
      m3_in = 1'b0;
    end else begin
      if (!m3_in && so3 === 1'b0) begin
        m3_in = 1'b1; m3_k = 0; m3_t = cyc;
      end
      if (m3_in) begin
        m3_sh = {m3_sh[31:0], so3};
        m3_k++;
        if (m3_k == 33) begin
          m3_ok = 1'b1;
          for (int j = 0; j < 11; j++) begin
            m3_g = m3_sh[32-3*j -: 3];
            m3_b[10-j] = m3_g[1];
            if (m3_g != 3'b000 && m3_g != 3'b111) m3_ok = 1'b0;
          end
          if (m3_b[10] !== 1'b0) m3_ok = 1'b0;
          q3.push_back('{fr: m3_b[9:1], stop: m3_b[0], ok: m3_ok, t: m3_t});
          m3_in = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Long division of {d, 0, f, 000} by 1011
  function automatic logic [2:0] crc_model(input logic [31:0] d, input logic [3:0] f);
    logic [39:0] r;
    r = {d, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [44:0] exp_res(input logic [31:0] d, input logic [3:0] f, input logic [2:0] cr);
    logic [2:0] k;
`ifdef MTM_ALU_TX_CRC_GEN_EN
    k = crc_model(d, f);
`else
    k = cr;
`endif
    return {1'b0, d[31:24], 1'b0, d[23:16], 1'b0, d[15:8], 1'b0, d[7:0], 1'b1, 1'b0, f, k};
  endfunction

  task automatic send(input logic sel, input logic e, input logic [31:0] cc, input logic [3:0] ff,
                      input logic [2:0] cr, input logic [2:0] ee, input logic hold, output int h);
    int n;
    n = 0;
    @(negedge clk);
    is_err = e; c = cc; fl = ff; crc = cr; ef = ee;
    if (sel) v3 = 1'b1; else v1 = 1'b1;
    while (((sel ? rdy3 : rdy1) !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_wait", 64'(n < 400), 64'd1);
    @(posedge clk);
    @(negedge clk);
    h = cyc;
    if (!hold) begin v1 = 1'b0; v3 = 1'b0; end
  endtask

  task automatic wait_ready(input logic sel, input int h, output int dur);
    int n;
    n = 0;
    while (((sel ? rdy3 : rdy1) !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    dur = cyc - h + 1;
  endtask

  task automatic take(input logic sel, input int n, input int h, input int sp,
                      output logic [44:0] fr, output logic good);
    mon_t m;
    fr = '0;
    good = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ((sel ? q3.size() : q1.size()) == 0) begin
        good = 1'b0;
        break;
      end
      if (sel) m = q3.pop_front(); else m = q1.pop_front();
      fr = {fr[35:0], m.fr};
      if (m.stop !== 1'b1 || m.ok !== 1'b1 || m.t != h + sp * i) good = 1'b0;
    end
    if (!sel && q1.size() > 0 && n == 5 && h < 0) good = 1'b0;
  endtask

  initial begin
    int          h, h2, dur;
    logic [44:0] fr;
    logic        good, line;
    logic [31:0] rc;
    logic [3:0]  rf;
    logic [2:0]  rk;

    #4_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          h, h2, dur;
    logic [44:0] fr;
    logic        good, line;
    logic [31:0] rc;
    logic [3:0]  rf;
    logic [2:0]  rk;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", {so1, rdy1, busy1, so3, rdy3, busy3}, 6'b110_110);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Result packet 12345678, flags 0, crc 101
    send(1'b0, 1'b0, 32'h1234_5678, 4'b0000, 3'b101, 3'b000, 1'b0, h);
    chk("busy_during_pkt", {rdy1, busy1}, 2'b01);
    wait_ready(1'b0, h, dur);
    chk("res_ready_latency", dur, 65);
    @(negedge clk);
    take(1'b0, 5, h, 13, fr, good);
`ifdef MTM_ALU_TX_CRC_GEN_EN
    chk("res_frames", fr, exp_res(32'h1234_5678, 4'b0000, 3'b101));
`else
    chk("res_frames", fr, {9'h012, 9'h034, 9'h056, 9'h078, 9'h105});
`endif
    chk("res_framing", good, 1'b1);

    // Error 100 -> C9
    send(1'b0, 1'b1, 32'h0, 4'b0000, 3'b000, 3'b100, 1'b0, h);
    wait_ready(1'b0, h, dur);
    chk("err_ready_latency", dur, 13);
    @(negedge clk);
    take(1'b0, 1, h, 13, fr, good);
    chk("err100_frame", fr, 45'h1C9);
    chk("err100_framing", good & (q1.size() == 0), 1'b1);

    // Error 011 with junk C/flags/crc -> B7 (parity over 1,0,1,1,0,1,1)
    send(1'b0, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b111, 3'b011, 1'b0, h);
    wait_ready(1'b0, h, dur);
    @(negedge clk);
    take(1'b0, 1, h, 13, fr, good);
    chk("err011_frame", fr, 45'h1B7);
    chk("err011_framing", good & (q1.size() == 0), 1'b1);

    // Back-to-back with inputs altered mid-packet
    send(1'b0, 1'b0, 32'hA5A5_0F0F, 4'b1010, 3'b011, 3'b000, 1'b1, h);
    is_err = 1'b0; c = 32'h0102_03FF; fl = 4'b0101; crc = 3'b110;
    wait_ready(1'b0, h, dur);
    chk("b2b_first_ready", dur, 65);
    @(posedge clk);
    @(negedge clk);
    h2 = cyc;
    v1 = 1'b0;
    chk("b2b_second_start", h2 - h, 65);
    wait_ready(1'b0, h2, dur);
    @(negedge clk);
    take(1'b0, 5, h, 13, fr, good);
    chk("b2b_pkt1", fr, exp_res(32'hA5A5_0F0F, 4'b1010, 3'b011));
    chk("b2b_pkt1_framing", good, 1'b1);
    take(1'b0, 5, h2, 13, fr, good);
    chk("b2b_pkt2", fr, exp_res(32'h0102_03FF, 4'b0101, 3'b110));
    chk("b2b_pkt2_framing", good & (q1.size() == 0), 1'b1);

    // Reset mid-packet
    send(1'b0, 1'b0, 32'h0000_FFFF, 4'b0011, 3'b001, 3'b000, 1'b0, h);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q1.delete();
    chk("reset_mid_pkt", {so1, rdy1, busy1}, 3'b110);
    @(negedge clk);
    reset = 1'b0;
    line = 1'b1;
    repeat (40) begin
      @(negedge clk);
      line = line & so1 & rdy1;
    end
    chk("reset_abort_line", {line, 32'(q1.size())}, {1'b1, 32'd0});

    // Random results, 1 cycle/bit
    for (int i = 0; i < 100; i++) begin
      rc = $urandom; rf = 4'($urandom); rk = 3'($urandom);
      send(1'b0, 1'b0, rc, rf, rk, 3'($urandom), 1'b0, h);
      wait_ready(1'b0, h, dur);
      chk("rand_latency", dur, 65);
      @(negedge clk);
      take(1'b0, 5, h, 13, fr, good);
      chk("rand_frames", fr, exp_res(rc, rf, rk));
      chk("rand_framing", good, 1'b1);
    end

    // Random results, 3 cycles/bit, no gap
    for (int i = 0; i < 8; i++) begin
      rc = $urandom; rf = 4'($urandom); rk = 3'($urandom);
      send(1'b1, 1'b0, rc, rf, rk, 3'b000, 1'b0, h);
      wait_ready(1'b1, h, dur);
      chk("bc3_latency", dur, 165);
      @(negedge clk);
      take(1'b1, 5, h, 33, fr, good);
      chk("bc3_frames", fr, exp_res(rc, rf, rk));
      chk("bc3_hold_framing", good & (q3.size() == 0), 1'b1);
    end

    // Error packet on 3 cycles/bit instance
    send(1'b1, 1'b1, 32'h0, 4'b0, 3'b0, 3'b100, 1'b0, h);
    wait_ready(1'b1, h, dur);
    chk("bc3_err_latency", dur, 33);
    @(negedge clk);
    take(1'b1, 1, h, 33, fr, good);
    chk("bc3_err_frame", fr, 45'h1C9);
    chk("bc3_err_framing", good & (q3.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
